// File: rtl/iterative_divider.sv
// iterative_divider: radix-2 restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor.
//   clk, rst              clock and asynchronous active-high reset
//   in_valid / in_ready   operand handshake (dividend, divisor)
//   out_valid / out_ready result handshake (quotient, remainder, flags)
//   div_by_zero           divisor was zero: quotient all ones, remainder = dividend low half
//   overflow              quotient would not fit in WIDTH bits: quotient all ones, remainder 0
// Normal operations take WIDTH iterations; error cases finish on the accept edge.
module iterative_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  // Partial remainder. It stays below the divisor, so its (WIDTH+1)-th bit is
  // always zero and is not stored; the trial value t carries the extra bit.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] lo;    // remaining dividend bits, consumed MSB-first
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             dbz, ovf;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             q_bit, err_dbz, err_ovf, last;

  always_comb begin
    t       = {r, lo[WIDTH-1]};
    q_bit   = (t >= {1'b0, dvsr});
    // True difference is < divisor when q_bit is set, so WIDTH bits suffice.
    diff    = t[WIDTH-1:0] - dvsr;
    err_dbz = (divisor == '0);
    err_ovf = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    last    = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (err_dbz || err_ovf) ? DONE : BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r    <= '0;
      lo   <= '0;
      dvsr <= '0;
      q    <= '0;
      cnt  <= '0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (err_dbz) begin
            dbz <= 1'b1;
            ovf <= 1'b0;
            q   <= '1;
            r   <= dividend[WIDTH-1:0];
          end else if (err_ovf) begin
            dbz <= 1'b0;
            ovf <= 1'b1;
            q   <= '1;
            r   <= '0;
          end else begin
            dvsr <= divisor;
            r    <= dividend[2*WIDTH-1:WIDTH];
            lo   <= dividend[WIDTH-1:0];
            q    <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          r   <= q_bit ? diff : t[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], q_bit};
          lo  <= {lo[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        DONE: if (out_ready) begin
          dbz <= 1'b0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q;
  assign remainder   = r;
  assign div_by_zero = dbz;
  assign overflow    = ovf;
endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=16): directed cases,
// backpressure, asynchronous reset mid-operation, back-to-back and random
// operands checked against a plain-arithmetic reference model.
module tb_iterative_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iterative_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Reference model straight from the arithmetic definition.
  function automatic void ref_div(input logic [31:0] dd, input logic [15:0] dv,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dbz, output logic ovf);
    longint unsigned a, b;
    a = longint'(dd);
    b = longint'(dv);
    dbz = 1'b0; ovf = 1'b0;
    if (dv == 16'd0) begin
      dbz = 1'b1; q = 16'hFFFF; r = dd[15:0];
    end else if (a / b > 64'hFFFF) begin
      ovf = 1'b1; q = 16'hFFFF; r = 16'd0;
    end else begin
      q = 16'(a / b); r = 16'(a % b);
    end
  endfunction

  // Drive one operation; report accept readiness, latency (edges after the
  // accepting edge until out_valid) and the captured result. Bounded wait.
  task automatic do_op(input logic [31:0] dd, input logic [15:0] dv,
                       output bit acc_rdy, output int lat,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dbz, output logic ovf);
    acc_rdy  = in_ready;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder; dbz = div_by_zero; ovf = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #23;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {2'b10, 32'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want rdy=1 vld=0 q=0 r=0 dbz=0 ovf=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] dds [7] = '{32'd1000000, 32'hFFFE0001, 32'hFFFEFFFF, 32'd5, 32'h00010000, 32'd0, 32'h0000FFFF};
    logic [15:0] dvs [7] = '{16'd1234,    16'hFFFF,     16'hFFFF,     16'd0, 16'd1,        16'd9, 16'd1};
    // Independent constants for the spec's worked examples.
    logic [15:0] kq  [5] = '{16'd810, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] kr  [5] = '{16'd460, 16'h0000, 16'hFFFE, 16'h0005, 16'h0000};
    bit acc; int lat;
    logic [15:0] q, r, eq, er; logic dbz, ovf, edbz, eovf;
    for (int i = 0; i < 7; i++) begin
      do_op(dds[i], dvs[i], acc, lat, q, r, dbz, ovf);
      ref_div(dds[i], dvs[i], eq, er, edbz, eovf);
      vectors++;
      if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
        miscompares++;
        $display("FAIL directed_%0d: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
                 i, q, r, dbz, ovf, eq, er, edbz, eovf);
      end
      if (i < 5) begin
        vectors++;
        if ({q, r} !== {kq[i], kr[i]}) begin
          miscompares++;
          $display("FAIL directed_const_%0d: got q=%h r=%h, want q=%h r=%h", i, q, r, kq[i], kr[i]);
        end
      end
      vectors++;
      if (lat != ((edbz || eovf) ? 0 : 16)) begin
        miscompares++;
        $display("FAIL latency_%0d: got %0d edges, want %0d", i, lat, (edbz || eovf) ? 0 : 16);
      end
      vectors++;
      if (!acc) begin
        miscompares++;
        $display("FAIL accept_ready_%0d: got in_ready=0, want 1", i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] q0, r0; int n;
    dividend = 32'd1000; divisor = 16'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    q0 = quotient; r0 = remainder;
    vectors++;
    if ({out_valid, q0, r0} !== {1'b1, 16'd333, 16'd1}) begin
      miscompares++;
      $display("FAIL bp_result: got vld=%b q=%0d r=%0d, want vld=1 q=333 r=1", out_valid, q0, r0);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2); dividend = 32'd0; divisor = 16'd0;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !== {2'b10, 16'd333, 16'd1, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b q=%0d r=%0d dbz=%b ovf=%b, want vld=1 rdy=0 q=333 r=1 dbz=0 ovf=0",
                 c, out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk); #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_ignored_pulse: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    bit acc; int lat; logic [15:0] q, r; logic dbz, ovf;
    dividend = 32'h1234_5678; divisor = 16'h4321; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {2'b10, 32'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_mid: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want rdy=1 vld=0 q=0 r=0 dbz=0 ovf=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: got out_valid=%b, want 0", out_valid);
    end
    do_op(32'd100, 16'd7, acc, lat, q, r, dbz, ovf);
    vectors++;
    if ({q, r, dbz, ovf, lat} !== {16'd14, 16'd2, 2'b00, 32'd16}) begin
      miscompares++;
      $display("FAIL after_reset_100_7: got q=%0d r=%0d dbz=%b ovf=%b lat=%0d, want q=14 r=2 dbz=0 ovf=0 lat=16",
               q, r, dbz, ovf, lat);
    end
  endtask

  task automatic test_random(input int n_ops);
    bit acc; int lat;
    logic [31:0] dd; logic [15:0] dv, q, r, eq, er; logic dbz, ovf, edbz, eovf;
    longint unsigned recon;
    for (int i = 0; i < n_ops; i++) begin
      case ($urandom_range(0, 15))
        0: begin dv = 16'd0; dd = $urandom; end
        1: begin dv = 16'($urandom_range(1, 65535)); dd = {16'($urandom_range(32'(dv), 65535)), 16'($urandom)}; end
        default: begin
          dv = 16'($urandom_range(1, 65535));
          dd = {16'($urandom_range(0, 32'(dv) - 1)), 16'($urandom)};
        end
      endcase
      do_op(dd, dv, acc, lat, q, r, dbz, ovf);
      ref_div(dd, dv, eq, er, edbz, eovf);
      vectors++;
      if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf} || !acc) begin
        miscompares++;
        $display("FAIL random_%0d %h/%h: got q=%h r=%h dbz=%b ovf=%b rdy=%b, want q=%h r=%h dbz=%b ovf=%b rdy=1",
                 i, dd, dv, q, r, dbz, ovf, acc, eq, er, edbz, eovf);
      end
      if (!edbz && !eovf) begin
        recon = longint'(q) * longint'(dv) + longint'(r);
        vectors++;
        if (recon != longint'(dd) || r >= dv) begin
          miscompares++;
          $display("FAIL identity_%0d: got q*d+r=%h r=%h, want %h with r<%h", i, recon, r, dd, dv);
        end
      end
    end
  endtask

  // Next operation presented the cycle right after each output handshake.
  task automatic test_back_to_back;
    bit acc; int lat; logic [15:0] q, r; logic dbz, ovf;
    for (int i = 0; i < 4; i++) begin
      do_op(32'd50000 + 32'(i), 16'd7 + 16'(i), acc, lat, q, r, dbz, ovf);
      vectors++;
      if (!acc || q !== 16'((50000 + i) / (7 + i)) || r !== 16'((50000 + i) % (7 + i))) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got rdy=%b q=%0d r=%0d, want rdy=1 q=%0d r=%0d",
                 i, acc, q, r, (50000 + i) / (7 + i), (50000 + i) % (7 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random(2500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
